ac_pixel_port: RTL and testbench



---
 rtl/ac_pixel_port.sv | 182 ++++++++++++++++++
 tb/tb_ac_pixel_port.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_pixel_port.sv
// Access-controller pixel port: buffers source pixels toward the upsampler and
// frames the upsampled pixels on an AXI-Stream master, one frame per start.

module ac_pixel_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

module ac_pixel_port #(
  parameter int SRC_W      = 960,
  parameter int SRC_H      = 540,
  parameter int UPSCALE    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        err_sof,
  input  logic [23:0] s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tuser,
  output logic        s_tready,
  output logic [23:0] ac_upsp_rdata,
  output logic        ac_upsp_rvalid,
  input  logic        upsp_ac_rready,
  input  logic [23:0] upsp_ac_wdata,
  input  logic        upsp_ac_wvalid,
  output logic        ac_upsp_wready,
  output logic [23:0] m_tdata,
  output logic        m_tvalid,
  output logic        m_tuser,
  output logic        m_tlast,
  input  logic        m_tready
);
  localparam int DATA_W  = 24;
  localparam int SRC_PIX = SRC_W * SRC_H;
  localparam int OUT_W   = SRC_W * UPSCALE;
  localparam int OUT_PIX = OUT_W * SRC_H * UPSCALE;
  localparam int IN_CW   = $clog2(SRC_PIX) + 1;
  localparam int OUT_CW  = $clog2(OUT_PIX) + 1;
  localparam int COL_CW  = $clog2(OUT_W) + 1;

  localparam logic [IN_CW-1:0]  SRC_PIX_C  = IN_CW'(SRC_PIX);
  localparam logic [OUT_CW-1:0] OUT_PIX_C  = OUT_CW'(OUT_PIX);
  localparam logic [COL_CW-1:0] OUT_W_LAST = COL_CW'(OUT_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IN_CW-1:0]   in_cnt;
  logic [OUT_CW-1:0]  wr_cnt;
  logic [OUT_CW-1:0]  out_cnt;
  logic [COL_CW-1:0]  col_cnt;
  logic               in_full;
  logic               in_empty;
  logic               out_full;
  logic               out_empty;
  logic               arm;
  logic               s_push;
  logic               r_pop;
  logic               w_push;
  logic               m_pop;

  assign arm            = (state == IDLE) && start;
  assign s_tready       = (state == RUN) && !in_full && (in_cnt < SRC_PIX_C);
  assign s_push         = s_tvalid && s_tready;
  assign ac_upsp_rvalid = !in_empty;
  assign r_pop          = ac_upsp_rvalid && upsp_ac_rready;
  assign ac_upsp_wready = ((state == RUN) || (state == DRAIN)) && !out_full && (wr_cnt < OUT_PIX_C);
  assign w_push         = upsp_ac_wvalid && ac_upsp_wready;
  assign m_tvalid       = !out_empty;
  assign m_pop          = m_tvalid && m_tready;
  assign m_tuser        = (out_cnt == '0);
  assign m_tlast        = (col_cnt == OUT_W_LAST);
  assign busy           = (state == RUN) || (state == DRAIN);
  assign frame_done     = (state == DONE);

  ac_pixel_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_push),
    .wdata (s_tdata),
    .pop   (r_pop),
    .rdata (ac_upsp_rdata),
    .full  (in_full),
    .empty (in_empty)
  );

  ac_pixel_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata (upsp_ac_wdata),
    .pop   (m_pop),
    .rdata (m_tdata),
    .full  (out_full),
    .empty (out_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        if (out_cnt == OUT_PIX_C)     state_nxt = DONE;
        else if (in_cnt == SRC_PIX_C) state_nxt = DRAIN;
      end
      DRAIN:   if (out_cnt == OUT_PIX_C) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Arming a frame wins over any idle-time output pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt  <= '0;
      wr_cnt  <= '0;
      out_cnt <= '0;
      col_cnt <= '0;
      err_sof <= 1'b0;
    end else if (arm) begin
      in_cnt  <= '0;
      wr_cnt  <= '0;
      out_cnt <= '0;
      col_cnt <= '0;
      err_sof <= 1'b0;
    end else begin
      if (s_push) begin
        in_cnt <= in_cnt + IN_CW'(1);
        if (s_tuser != (in_cnt == '0)) err_sof <= 1'b1;
      end
      if (w_push) wr_cnt <= wr_cnt + OUT_CW'(1);
      if (m_pop) begin
        out_cnt <= out_cnt + OUT_CW'(1);
        col_cnt <= (col_cnt == OUT_W_LAST) ? '0 : col_cnt + COL_CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_ac_pixel_port.sv
// Bench for ac_pixel_port: queue-based frame model compared every cycle, plus
// per-frame end-to-end pixel/marker checks and hand-computed literals.

module tb_ac_pixel_port;
  localparam int SRC_W = 4, SRC_H = 2, UPSCALE = 2, FIFO_DEPTH = 4;
  localparam int SRC_PIX = SRC_W * SRC_H;
  localparam int OUT_W   = SRC_W * UPSCALE;
  localparam int OUT_PIX = OUT_W * SRC_H * UPSCALE;
  localparam int FAN     = UPSCALE * UPSCALE;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic        busy, frame_done, err_sof;
  logic [23:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tuser = 1'b0, s_tready;
  logic [23:0] ac_upsp_rdata;
  logic        ac_upsp_rvalid, upsp_ac_rready = 1'b0;
  logic [23:0] upsp_ac_wdata = '0;
  logic        upsp_ac_wvalid = 1'b0, ac_upsp_wready;
  logic [23:0] m_tdata;
  logic        m_tvalid, m_tuser, m_tlast, m_tready = 1'b0;

  ac_pixel_port #(.SRC_W(SRC_W), .SRC_H(SRC_H), .UPSCALE(UPSCALE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done), .err_sof(err_sof),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tuser(s_tuser), .s_tready(s_tready),
    .ac_upsp_rdata(ac_upsp_rdata), .ac_upsp_rvalid(ac_upsp_rvalid), .upsp_ac_rready(upsp_ac_rready),
    .upsp_ac_wdata(upsp_ac_wdata), .upsp_ac_wvalid(upsp_ac_wvalid), .ac_upsp_wready(ac_upsp_wready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tready(m_tready)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: frame phase, two queues, counts
  logic [23:0] q_in[$];
  logic [23:0] q_out[$];
  int ph = 0, ni = 0, nw = 0, no = 0;   // ph: 0 idle, 1 run, 2 drain, 3 done
  bit merr = 1'b0;

  function automatic bit e_sready();
    return (ph == 1) && (q_in.size() < FIFO_DEPTH) && (ni < SRC_PIX);
  endfunction
  function automatic bit e_wready();
    return (ph == 1 || ph == 2) && (q_out.size() < FIFO_DEPTH) && (nw < OUT_PIX);
  endfunction
  function automatic logic [23:0] e_rdata();
    if (q_in.size() > 0) return q_in[0];
    return 24'd0;
  endfunction
  function automatic logic [23:0] e_mdata();
    if (q_out.size() > 0) return q_out[0];
    return 24'd0;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit sp, rp, wp, mp;
    int nph;
    if (rst) begin
      q_in.delete(); q_out.delete();
      ph = 0; ni = 0; nw = 0; no = 0; merr = 1'b0;
    end else begin
      sp = s_tvalid && e_sready();
      rp = (q_in.size() > 0) && upsp_ac_rready;
      wp = upsp_ac_wvalid && e_wready();
      mp = (q_out.size() > 0) && m_tready;
      nph = ph;
      case (ph)
        0: if (start) nph = 1;
        1: if (no == OUT_PIX) nph = 3; else if (ni == SRC_PIX) nph = 2;
        2: if (no == OUT_PIX) nph = 3;
        default: nph = 0;
      endcase
      if (rp) void'(q_in.pop_front());
      if (sp) begin
        if (s_tuser != (ni == 0)) merr = 1'b1;
        q_in.push_back(s_tdata);
        ni++;
      end
      if (mp) begin void'(q_out.pop_front()); no++; end
      if (wp) begin q_out.push_back(upsp_ac_wdata); nw++; end
      if (ph == 0 && nph == 1) begin ni = 0; nw = 0; no = 0; merr = 1'b0; end
      ph = nph;
    end
  end

  // ---------------- per-cycle compare
  int  fd_cnt = 0, fd_cyc = 0;
  bit  m_hold = 1'b0, r_hold = 1'b0;
  logic [23:0] m_prev = '0, r_prev = '0;

  always @(negedge clk) begin
    #1;
    chk("s_tready",   32'(s_tready),       32'(e_sready()));
    chk("rvalid",     32'(ac_upsp_rvalid), 32'(q_in.size() > 0));
    chk("rdata",      32'(ac_upsp_rdata),  32'(e_rdata()));
    chk("wready",     32'(ac_upsp_wready), 32'(e_wready()));
    chk("m_tvalid",   32'(m_tvalid),       32'(q_out.size() > 0));
    chk("m_tdata",    32'(m_tdata),        32'(e_mdata()));
    chk("m_tuser",    32'(m_tuser),        32'(no == 0));
    chk("m_tlast",    32'(m_tlast),        32'((no % OUT_W) == OUT_W - 1));
    chk("busy",       32'(busy),           32'(ph == 1 || ph == 2));
    chk("frame_done", 32'(frame_done),     32'(ph == 3));
    chk("err_sof",    32'(err_sof),        32'(merr));
    if (m_hold && !rst) chk("m_tdata_stable", 32'(m_tdata), 32'(m_prev));
    if (r_hold && !rst) chk("rdata_stable", 32'(ac_upsp_rdata), 32'(r_prev));
    m_hold = m_tvalid && !m_tready && !rst;
    r_hold = ac_upsp_rvalid && !upsp_ac_rready && !rst;
    m_prev = m_tdata;
    r_prev = ac_upsp_rdata;
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
  end

  // ---------------- upsampler and sink driver (FAN pixels returned per pop)
  int  rr_mode = 0, mr_mode = 0;  // 0 low, 1 high, 2 random, 3 toggle (sink only)
  bit  wv_rand = 1'b0;
  logic [23:0] pend[$];
  logic [23:0] rlog[$];
  logic [25:0] mlog[$];
  int  n_wpush = 0, last_pop_cyc = 0;

  always @(negedge clk) begin : drv
    bit rr, mr;
    case (rr_mode)
      0: rr = 1'b0;
      1: rr = 1'b1;
      default: rr = 1'($urandom_range(1));
    endcase
    case (mr_mode)
      0: mr = 1'b0;
      1: mr = 1'b1;
      2: mr = 1'($urandom_range(1));
      default: mr = ~m_tready;
    endcase
    if (rst) begin
      pend.delete();
      upsp_ac_rready = 1'b0;
      upsp_ac_wvalid = 1'b0;
      m_tready = mr;
    end else begin
      upsp_ac_rready = rr;
      m_tready = mr;
      upsp_ac_wvalid = (pend.size() > 0) && (!wv_rand || $urandom_range(3) != 0);
      upsp_ac_wdata  = (pend.size() > 0) ? pend[0] : 24'd0;
      if (upsp_ac_wvalid && ac_upsp_wready) begin void'(pend.pop_front()); n_wpush++; end
      if (ac_upsp_rvalid && rr) begin
        rlog.push_back(ac_upsp_rdata);
        for (int k = 0; k < FAN; k++) pend.push_back(ac_upsp_rdata + 24'(k));
      end
      if (m_tvalid && mr) begin
        mlog.push_back({m_tuser, m_tlast, m_tdata});
        last_pop_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus helpers
  logic [23:0] src [SRC_PIX];
  bit          usr [SRC_PIX];
  int  sidx = 0;
  bit  gaps_on = 1'b0;

  task automatic set_src(input bit rnd);
    for (int i = 0; i < SRC_PIX; i++) begin
      src[i] = rnd ? 24'($urandom) : 24'(i + 1);
      usr[i] = (i == 0);
    end
    sidx = 0;
    rlog.delete(); mlog.delete();
  endtask

  task automatic start_frame();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic push_n(input int n);
    int done_n = 0, g = 0;
    while (done_n < n && g < 2000) begin
      @(negedge clk); g++;
      if (gaps_on && $urandom_range(3) == 0) s_tvalid = 1'b0;
      else begin
        s_tvalid = 1'b1; s_tdata = src[sidx]; s_tuser = usr[sidx];
        if (s_tready) begin sidx++; done_n++; end
      end
    end
    @(negedge clk); s_tvalid = 1'b0;
    chk("push_done", 32'(done_n), 32'(n));
  endtask

  task automatic wait_done(input int limit);
    int base = fd_cnt, n = 0;
    while (fd_cnt == base && n < limit) begin @(negedge clk); n++; end
    #2;
    chk("frame_done_seen", 32'(fd_cnt - base), 32'd1);
  endtask

  task automatic check_frame();
    logic [23:0] exp_d;
    chk("r_count", 32'(rlog.size()), 32'(SRC_PIX));
    for (int i = 0; i < SRC_PIX && i < rlog.size(); i++) chk("rdata_order", 32'(rlog[i]), 32'(src[i]));
    chk("m_count", 32'(mlog.size()), 32'(OUT_PIX));
    for (int j = 0; j < OUT_PIX && j < mlog.size(); j++) begin
      exp_d = src[j / FAN] + 24'(j % FAN);
      chk("m_beat_data", 32'(mlog[j][23:0]), 32'(exp_d));
      chk("m_beat_tuser", 32'(mlog[j][25]), 32'(j == 0));
      chk("m_beat_tlast", 32'(mlog[j][24]), 32'((j % OUT_W) == OUT_W - 1));
    end
  endtask

  task automatic run_frame();
    start_frame();
    push_n(SRC_PIX);
    wait_done(3000);
    check_frame();
  endtask

  // ---------------- test sequence
  initial begin
    int pushes, g, base;
    int last_idx [4] = '{7, 15, 23, 31};

    // reset held 3 cycles, then 10 idle cycles
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    chk("idle_s_tready", 32'(s_tready), 32'd0);
    chk("idle_m_tuser",  32'(m_tuser),  32'd1);
    chk("idle_busy",     32'(busy),     32'd0);
    chk("idle_m_tdata",  32'(m_tdata),  32'd0);

    // nominal frame, pixels 1..8
    rr_mode = 1; mr_mode = 1;
    set_src(1'b0);
    run_frame();
    for (int i = 0; i < SRC_PIX && i < rlog.size(); i++) chk("nom_rdata_lit", 32'(rlog[i]), 32'(i + 1));
    for (int i = 0; i < 4; i++)
      if (last_idx[i] < mlog.size()) chk("nom_tlast_lit", 32'(mlog[last_idx[i]][24]), 32'd1);
    if (mlog.size() == OUT_PIX) begin
      chk("nom_beat5_lit",  32'(mlog[5][23:0]),  32'h000003);
      chk("nom_beat31_lit", 32'(mlog[31][23:0]), 32'h00000b);
      chk("nom_beat0_tuser", 32'(mlog[0][25]), 32'd1);
    end
    chk("nom_fd_latency", 32'(fd_cyc - last_pop_cyc), 32'd2);
    chk("nom_err_sof", 32'(err_sof), 32'd0);

    // input backpressure: upsampler not reading
    rr_mode = 0; mr_mode = 1;
    set_src(1'b1);
    start_frame();
    pushes = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      s_tvalid = 1'b1; s_tdata = src[pushes]; s_tuser = usr[pushes];
      if (s_tready) pushes++;
    end
    #2;
    chk("in_bp_pushes", 32'(pushes), 32'(FIFO_DEPTH));
    chk("in_bp_sready", 32'(s_tready), 32'd0);
    rr_mode = 1;
    g = 0;
    while (pushes < SRC_PIX && g < 500) begin
      @(negedge clk); g++;
      s_tvalid = 1'b1; s_tdata = src[pushes]; s_tuser = usr[pushes];
      if (s_tready) pushes++;
    end
    @(negedge clk); s_tvalid = 1'b0;
    chk("in_bp_all_pushed", 32'(pushes), 32'(SRC_PIX));
    wait_done(3000);
    check_frame();

    // output backpressure: sink stalled, then toggling
    rr_mode = 1; mr_mode = 0;
    set_src(1'b1);
    start_frame();
    base = n_wpush;
    push_n(SRC_PIX);
    repeat (10) @(negedge clk);
    #2;
    chk("out_bp_wpush", 32'(n_wpush - base), 32'(FIFO_DEPTH));
    chk("out_bp_wready", 32'(ac_upsp_wready), 32'd0);
    mr_mode = 3;
    wait_done(3000);
    check_frame();

    // SOF error: tuser low on first pixel, high on third
    mr_mode = 1;
    set_src(1'b1);
    usr[0] = 1'b0; usr[2] = 1'b1;
    start_frame();
    push_n(1);
    #2 chk("sof_err_set", 32'(err_sof), 32'd1);
    push_n(SRC_PIX - 1);
    wait_done(3000);
    check_frame();
    chk("sof_err_sticky", 32'(err_sof), 32'd1);
    set_src(1'b1);
    start_frame();
    #2 chk("sof_err_cleared", 32'(err_sof), 32'd0);
    push_n(SRC_PIX);
    wait_done(3000);
    check_frame();

    // mid-frame reset with an ignored start
    rr_mode = 0; mr_mode = 1;
    set_src(1'b1);
    start_frame();
    push_n(3);
    start_frame();
    push_n(1);
    #2 chk("ignored_start_busy", 32'(busy), 32'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("rst_rvalid", 32'(ac_upsp_rvalid), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #2 rst = 1'b0;

    // randomized frames: random data, gaps, ready and valid patterns
    rr_mode = 2; mr_mode = 2; wv_rand = 1'b1; gaps_on = 1'b1;
    for (int f = 0; f < 4; f++) begin
      set_src(1'b1);
      run_frame();
      if (mlog.size() > 0) chk("rand_first_tuser", 32'(mlog[0][25]), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
